// File: rtl/xmul_arbiter.sv
// xmul_arbiter
//   Shares one 2-stage multiplier (operand regs + result reg) between N_REQ
//   requesters. A round-robin arbiter picks one valid requester per cycle.
//   The winner's operands are registered toward the multiplier. Its function
//   select is delayed one extra stage so that it lines up with the product.
//   A requester-ID tag rides alongside, so the result returns as a one-hot
//   pulse to the requester that issued the op.
//
// Optional feature: define XMUL_ARB_LOCK_EN to add i_req_lock. An accepted
//   request with its lock bit set keeps the grant on the same requester until
//   that requester completes an accept with the lock bit clear.
//
// Ports
//   clk, rst      clock; asynchronous active-high reset
//   i_req_valid   per-requester request valid
//   o_req_ready   per-requester grant (one-hot or zero)
//   i_req_a/b     packed operands, requester i at [i*DATA_W +: DATA_W]
//   i_req_fns     packed function selects, requester i at [i*FNS_W +: FNS_W]
//   i_req_lock    grant-lock request (XMUL_ARB_LOCK_EN only)
//   o_res_valid   one-hot result pulse to the owning requester
//   o_res_data    result, qualified by o_res_valid
//   o_mul_a/b     operands to the multiplier
//   o_mul_fns     function select to the multiplier result stage
//   i_mul_res     multiplier result register
//   o_busy        any op in flight
module xmul_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int FNS_W  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          i_req_valid,
  output logic [N_REQ-1:0]          o_req_ready,
  input  logic [N_REQ*DATA_W-1:0]   i_req_a,
  input  logic [N_REQ*DATA_W-1:0]   i_req_b,
  input  logic [N_REQ*FNS_W-1:0]    i_req_fns,
`ifdef XMUL_ARB_LOCK_EN
  input  logic [N_REQ-1:0]          i_req_lock,
`endif
  output logic [N_REQ-1:0]          o_res_valid,
  output logic [DATA_W-1:0]         o_res_data,
  output logic [DATA_W-1:0]         o_mul_a,
  output logic [DATA_W-1:0]         o_mul_b,
  output logic [FNS_W-1:0]          o_mul_fns,
  input  logic [DATA_W-1:0]         i_mul_res,
  output logic                      o_busy
);

  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]  w_elig;
  logic [N_REQ-1:0]  w_grant;
  logic              w_accept;
  logic [IDW-1:0]    w_gnt_id;
  logic [IDW-1:0]    w_idx;
  logic [IDW:0]      w_sum;
  logic [IDW-1:0]    w_ptr_nxt;

  logic [IDW-1:0]    r_ptr;
  logic [DATA_W-1:0] r_mul_a;
  logic [DATA_W-1:0] r_mul_b;
  logic [FNS_W-1:0]  r_fns_s1;
  logic [FNS_W-1:0]  r_fns_s2;
  logic [2:0]        r_tag_v;
  logic [IDW-1:0]    r_tag_id0;
  logic [IDW-1:0]    r_tag_id1;
  logic [IDW-1:0]    r_tag_id2;

`ifdef XMUL_ARB_LOCK_EN
  logic              r_locked;
  logic [IDW-1:0]    r_owner;

  // While locked only the owner competes; everyone else waits.
  always_comb begin
    w_elig = i_req_valid;
    if (r_locked) w_elig = i_req_valid & (N_REQ'(1) << r_owner);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_locked <= 1'b0;
      r_owner  <= '0;
    end else if (w_accept) begin
      r_locked <= i_req_lock[w_gnt_id];
      if (i_req_lock[w_gnt_id]) r_owner <= w_gnt_id;
    end
  end
`else
  assign w_elig = i_req_valid;
`endif

  // Rotating priority search starting at r_ptr; the first hit wins.
  always_comb begin
    w_grant  = '0;
    w_gnt_id = '0;
    w_accept = 1'b0;
    w_sum    = '0;
    w_idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
      w_idx = (w_sum >= (IDW+1)'(N_REQ)) ? IDW'(w_sum - (IDW+1)'(N_REQ))
                                         : w_sum[IDW-1:0];
      if (!w_accept && w_elig[w_idx]) begin
        w_accept = 1'b1;
        w_gnt_id = w_idx;
      end
    end
    if (rst) w_accept = 1'b0;
    if (w_accept) w_grant[w_gnt_id] = 1'b1;
  end

  assign o_req_ready = w_grant;
  assign w_ptr_nxt   = (w_gnt_id == IDW'(N_REQ - 1)) ? '0 : w_gnt_id + 1'b1;

  // Operand stage, delayed fns stage and tag pipe. Idle slots load zero so
  // the multiplier sees clean inputs when nothing is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr     <= '0;
      r_mul_a   <= '0;
      r_mul_b   <= '0;
      r_fns_s1  <= '0;
      r_fns_s2  <= '0;
      r_tag_v   <= '0;
      r_tag_id0 <= '0;
      r_tag_id1 <= '0;
      r_tag_id2 <= '0;
    end else begin
      if (w_accept) r_ptr <= w_ptr_nxt;
      r_mul_a   <= w_accept ? i_req_a[int'(w_gnt_id)*DATA_W +: DATA_W] : '0;
      r_mul_b   <= w_accept ? i_req_b[int'(w_gnt_id)*DATA_W +: DATA_W] : '0;
      r_fns_s1  <= w_accept ? i_req_fns[int'(w_gnt_id)*FNS_W +: FNS_W] : '0;
      r_fns_s2  <= r_fns_s1;
      r_tag_v   <= {r_tag_v[1:0], w_accept};
      r_tag_id0 <= w_gnt_id;
      r_tag_id1 <= r_tag_id0;
      r_tag_id2 <= r_tag_id1;
    end
  end

  assign o_mul_a     = r_mul_a;
  assign o_mul_b     = r_mul_b;
  assign o_mul_fns   = r_fns_s2;
  assign o_res_valid = r_tag_v[2] ? (N_REQ'(1) << r_tag_id2) : '0;
  assign o_res_data  = r_tag_v[2] ? i_mul_res : '0;
  assign o_busy      = |r_tag_v;

endmodule
